// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port arbiter and setup/strobe/hold sequencer
// for a single-ported RAM with a bidirectional data bus.
module ram_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 8,
  parameter int STROBE_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rws,
  output logic          ram_cs,
  inout  wire  [DW-1:0] ram_io
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t        r_state, w_next;
  logic [3:0]    r_cnt;
  logic          r_grant, r_last, r_we, r_cs, r_ack0, r_ack1, r_busy;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata0, r_rdata1;
  logic          w_any, w_gnt;
  assign w_any = req0 | req1;
  // under contention the port not served last wins
  assign w_gnt = (req0 && req1) ? ~r_last : req1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_any ? SETUP : IDLE;
      SETUP:   w_next = STROBE;
      STROBE:  w_next = (r_cnt == 4'd0) ? HOLD : STROBE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_cs     <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_busy   <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_next;
      r_cs    <= w_next == STROBE;
      r_busy  <= w_next != IDLE;
      r_ack0  <= w_next == HOLD && !r_grant;
      r_ack1  <= w_next == HOLD && r_grant;
      if (r_state == IDLE && w_any) begin
        r_grant <= w_gnt;
        r_last  <= w_gnt;
        r_we    <= w_gnt ? we1 : we0;
        r_addr  <= w_gnt ? addr1 : addr0;
        r_wdata <= w_gnt ? wdata1 : wdata0;
      end else if (w_next == IDLE) begin
        r_we <= 1'b0;
      end
      if (r_state == SETUP)
        r_cnt <= 4'(STROBE_CYC - 1);
      else if (r_state == STROBE && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (r_state == STROBE && r_cnt == 4'd0 && !r_we) begin
        if (r_grant) r_rdata1 <= ram_io;
        else         r_rdata0 <= ram_io;
      end
    end
  end
  assign ram_io   = r_we ? r_wdata : 'z;
  assign ram_rws  = r_we;
  assign ram_cs   = r_cs;
  assign ram_addr = r_addr;
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign busy     = r_busy;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed table, contention/reset sequences and random
// traffic against a transaction-level memory model of the arbiter.
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int SC = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, busy, ram_rws, ram_cs;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] rdata0, rdata1;
  wire  [DW-1:0] ram_io;
  logic [DW-1:0] tb_ram [1024];
  int model_mem [1024];
  int passed = 0, total = 0, last_port = 1;

  typedef struct {int p; int we; int a; int d; int exp;} vec_t;
  vec_t vt [6];

  ram_arbiter #(.AW(AW), .DW(DW), .STROBE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .ram_addr(ram_addr), .ram_rws(ram_rws), .ram_cs(ram_cs), .ram_io(ram_io)
  );

  assign ram_io = (ram_cs && !ram_rws) ? tb_ram[ram_addr] : 'z;
  always @(posedge clk) if (ram_cs && ram_rws) tb_ram[ram_addr] <= ram_io;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", n, act, exp);
  endtask

  task automatic set_req(input int p, input bit v, input int we, input int a, input int d);
    if (p == 0) begin
      req0 = v; we0 = we[0]; addr0 = AW'(a); wdata0 = DW'(d);
    end else begin
      req1 = v; we1 = we[0]; addr1 = AW'(a); wdata1 = DW'(d);
    end
  endtask

  task automatic do_access(input int p, input int we, input int a, input int d, input int exp);
    int ack_at = 0, cs_n = 0;
    bit addr_ok = 1, io_ok = 1, other = 0;
    @(negedge clk);
    set_req(p, 1, we, a, d);
    for (int k = 1; k <= 12 && ack_at == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("busy_rise", busy, 1);
        chk("cs_low_setup", ram_cs, 0);
      end
      cs_n += int'(ram_cs);
      if (ram_addr != AW'(a) || ram_rws != we[0]) addr_ok = 0;
      if (we != 0 && ram_io !== DW'(d)) io_ok = 0;
      if ((p == 0) ? ack1 : ack0) other = 1;
      if ((p == 0) ? ack0 : ack1) begin
        ack_at = k;
        set_req(p, 0, 0, 0, 0);
      end
    end
    set_req(p, 0, 0, 0, 0);
    chk("ack_cycle", ack_at, SC + 2);
    chk("cs_cycles", cs_n, SC);
    chk("addr_rws_stable", int'(addr_ok), 1);
    chk("other_ack", int'(other), 0);
    if (we != 0) begin
      chk("wdata_on_io", int'(io_ok), 1);
      model_mem[a] = d & 8'hFF;
    end else begin
      chk("rdata", int'((p == 0) ? rdata0 : rdata1), exp);
    end
    @(negedge clk);
    chk("idle_after_hold", int'(busy | ram_cs | ack0 | ack1), 0);
    last_port = p;
  endtask

  initial begin
    int q[$];
    int cyc[$];
    int first, cs_tot, issued, done, prev;
    bit both;
    int pend[2], gap[2], pa[2], pwe[2], pd[2];
    for (int i = 0; i < 1024; i++) begin
      tb_ram[i] = '0;
      model_mem[i] = 0;
    end
    vt = '{'{0, 1, 0, 4, 0}, '{0, 0, 0, 0, 4}, '{0, 1, 602, 95, 0},
           '{1, 1, 1023, 168, 0}, '{1, 0, 602, 0, 95}, '{0, 0, 1023, 0, 168}};
    // reset with random inputs
    repeat (4) begin
      @(negedge clk);
      set_req(0, 1'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)));
      set_req(1, 1'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)));
    end
    chk("rst_cs", ram_cs, 0);
    chk("rst_rws", ram_rws, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_busy", busy, 0);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // simultaneous first requests
    @(negedge clk);
    set_req(0, 1, 1, 62, 15);
    set_req(1, 1, 1, 217, 46);
    for (int k = 0; k < 30 && q.size() < 2; k++) begin
      @(negedge clk);
      if (ack0) begin q.push_back(0); set_req(0, 0, 0, 0, 0); end
      if (ack1) begin q.push_back(1); set_req(1, 0, 0, 0, 0); end
    end
    chk("sim_ack_count", q.size(), 2);
    if (q.size() == 2) begin
      chk("sim_first", q[0], 0);
      chk("sim_second", q[1], 1);
    end
    model_mem[62] = 15;
    model_mem[217] = 46;
    @(negedge clk);
    do_access(0, 0, 62, 0, 15);
    do_access(1, 0, 217, 0, 46);
    // directed table
    for (int i = 0; i < 6; i++) do_access(vt[i].p, vt[i].we, vt[i].a, vt[i].d, vt[i].exp);
    // continuous contention
    first = 1 - last_port;
    q.delete();
    cs_tot = 0;
    both = 0;
    @(negedge clk);
    set_req(0, 1, 0, 0, 0);
    set_req(1, 1, 0, 1023, 0);
    for (int k = 0; k < 60 && q.size() < 6; k++) begin
      @(negedge clk);
      cs_tot += int'(ram_cs);
      if (ack0 && ack1) both = 1;
      if (ack0) begin q.push_back(0); cyc.push_back(k); end
      if (ack1) begin q.push_back(1); cyc.push_back(k); end
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    chk("cont_ack_count", q.size(), 6);
    chk("cont_double_ack", int'(both), 0);
    chk("cont_cs_total", cs_tot, 6 * SC);
    for (int j = 0; j < q.size(); j++) chk("cont_order", q[j], (first + j) % 2);
    for (int j = 1; j < cyc.size(); j++) chk("cont_spacing", cyc[j] - cyc[j-1], SC + 3);
    chk("cont_rdata0", rdata0, model_mem[0]);
    chk("cont_rdata1", rdata1, model_mem[1023]);
    repeat (2) @(negedge clk);
    // random traffic against the memory model
    issued = 0; done = 0; prev = -100; both = 0;
    for (int p = 0; p < 2; p++) begin pend[p] = 0; gap[p] = 0; end
    for (int c = 0; c < 3000 && done < 40; c++) begin
      @(negedge clk);
      if (ack0 && ack1) both = 1;
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? ack0 : ack1) begin
          chk("rnd_ack_pending", pend[p], 1);
          chk("rnd_ack_spacing", int'(c - prev >= SC + 3), 1);
          prev = c;
          if (pwe[p] != 0) model_mem[pa[p]] = pd[p];
          else chk("rnd_rdata", int'((p == 0) ? rdata0 : rdata1), model_mem[pa[p]]);
          pend[p] = 0;
          gap[p] = int'($urandom_range(0, 3));
          set_req(p, 0, 0, 0, 0);
          done++;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (pend[p] == 0 && gap[p] == 0 && issued < 40) begin
          pa[p] = int'($urandom_range(0, 1023));
          pwe[p] = int'($urandom_range(0, 1));
          pd[p] = int'($urandom_range(0, 255));
          set_req(p, 1, pwe[p], pa[p], pd[p]);
          pend[p] = 1;
          issued++;
        end else if (gap[p] > 0) gap[p]--;
      end
    end
    chk("rnd_done", done, 40);
    chk("rnd_double_ack", int'(both), 0);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    // reset during strobe of a port 1 write
    set_req(1, 1, 1, 1015, 135);
    repeat (2) @(negedge clk);
    chk("mid_cs_high", ram_cs, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_cs_drop", ram_cs, 0);
    chk("mid_busy_drop", busy, 0);
    chk("mid_rws_drop", ram_rws, 0);
    set_req(1, 0, 0, 0, 0);
    both = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 || ack1) both = 1;
    end
    chk("mid_no_ack", int'(both), 0);
    chk("mid_rdata1_reset", rdata1, 0);
    rst_n = 1'b1;
    do_access(1, 0, 0, 0, model_mem[0]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
